ti_psg_gen: RTL and testbench

Tone and noise generator front end for the SN76489 sound path. It accepts SN76489-format command bytes and holds the three 10-bit tone registers, four 4-bit attenuation registers and the 3-bit noise control register. It runs three square-wave tone dividers and the 15-bit noise LFSR. Its `ch0out`–`ch3out` and `vol0`–`vol3` outputs connect directly to the same-named inputs of `ti_mixer`.

---
 rtl/ti_pkg.sv | 36 +++
 rtl/ti_psg_gen_if.sv | 10 +
 rtl/ti_tone_channel.sv | 40 ++++
 rtl/ti_psg_gen.sv | 137 +++++++++++++
 tb/tb_ti_psg_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ti_pkg.sv
// rtl/ti_pkg.sv - shared types, constants and helpers for the SN76489 tone/noise generator
package ti_pkg;

  typedef logic [9:0] tone_t;
  typedef logic [3:0] vol_t;

  typedef struct packed {
    logic       white;
    logic [1:0] rate;
  } noise_ctrl_t;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h4000;

  localparam int NOISE_P0 = 32;
  localparam int NOISE_P1 = 64;
  localparam int NOISE_P2 = 128;
  localparam int NCNT_W   = 7;

  // Last count value of the noise tick divider for rates 0..2 (rate 3 is clocked by tone 2).
  function automatic logic [NCNT_W-1:0] noise_last(input logic [1:0] rate);
    case (rate)
      2'd0:    return NCNT_W'(NOISE_P0 - 1);
      2'd1:    return NCNT_W'(NOISE_P1 - 1);
      default: return NCNT_W'(NOISE_P2 - 1);
    endcase
  endfunction

  // One LFSR step: feedback enters at the top, bit 0 is the audible output.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l, input logic white);
    logic fb;
    fb = white ? (l[0] ^ l[1]) : l[0];
    return {fb, l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/ti_psg_gen_if.sv
// rtl/ti_psg_gen_if.sv - command byte write port of the tone/noise generator
interface ti_psg_gen_if;

  logic       wr_en;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_data);
  modport slave  (input  wr_en, input  wr_data);

endinterface

// File: rtl/ti_tone_channel.sv
// rtl/ti_tone_channel.sv - one square-wave tone divider
module ti_tone_channel
  import ti_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  tick,
  input  tone_t tone,
  output logic  out,
  output logic  rise
);

  tone_t cnt;
  logic  sq;
  logic  reload;
  logic  audible;

  // A counter at 0 or 1 reloads on the tick, so a tone of N gives N ticks per half period.
  assign reload  = tick && (cnt <= tone_t'(1));
  // Tone values 0 and 1 hold the output high regardless of the square-wave state.
  assign audible = (tone > tone_t'(1));

  // Half-period counter: reload from the current tone value and flip the square wave.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (reload) begin
      cnt <= tone;
      sq  <= ~sq;
    end else if (tick) begin
      cnt <= cnt - tone_t'(1);
    end
  end

  assign out  = audible ? sq : 1'b1;
  // The output goes 0->1 on this edge: the noise generator uses it as its rate-3 clock.
  assign rise = reload && !sq && audible;

endmodule

// File: rtl/ti_psg_gen.sv
// rtl/ti_psg_gen.sv - SN76489 command decode, tone dividers and noise LFSR
module ti_psg_gen
  import ti_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic        CLK,
  input  logic        RST,
  ti_psg_gen_if.slave wr,
  output vol_t        vol0,
  output vol_t        vol1,
  output vol_t        vol2,
  output vol_t        vol3,
  output logic        ch0out,
  output logic        ch1out,
  output logic        ch2out,
  output logic        ch3out
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick;

  vol_t              vol_r [4];
  tone_t             tone_r [3];
  noise_ctrl_t       noise_r;
  logic [1:0]        latch_ch;
  logic              latch_vol;

  logic [1:0]        tgt_ch;
  logic              tgt_vol;
  logic              noise_wr;

  logic [LFSR_W-1:0] lfsr;
  logic [NCNT_W-1:0] ncnt;
  logic              shift_due;

  logic [2:0]        ch_out;
  logic [2:0]        ch_rise;
  logic              unused_rise;

  assign tick = (pre_cnt == PRE_LAST);

  // Generator tick prescaler.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // A latch byte names its own target; a data byte reuses the last latched one.
  always_comb begin
    tgt_ch  = wr.wr_data[7] ? wr.wr_data[6:5] : latch_ch;
    tgt_vol = wr.wr_data[7] ? wr.wr_data[4]   : latch_vol;
  end

  assign noise_wr = wr.wr_en && !tgt_vol && (tgt_ch == 2'd3);

  // Command decode into the volume, tone and noise control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vol_r     <= '{default: 4'hF};
      tone_r    <= '{default: '0};
      noise_r   <= '0;
      latch_ch  <= 2'd0;
      latch_vol <= 1'b0;
    end else if (wr.wr_en) begin
      if (wr.wr_data[7]) begin
        latch_ch  <= wr.wr_data[6:5];
        latch_vol <= wr.wr_data[4];
      end
      if (tgt_vol) begin
        vol_r[tgt_ch] <= wr.wr_data[3:0];
      end else if (noise_wr) begin
        noise_r <= noise_ctrl_t'(wr.wr_data[2:0]);
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (tgt_ch == 2'(i)) begin
            if (wr.wr_data[7]) begin
              tone_r[i][3:0] <= wr.wr_data[3:0];
            end else begin
              tone_r[i][9:4] <= wr.wr_data[5:0];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    ti_tone_channel u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .tone (tone_r[g]),
      .out  (ch_out[g]),
      .rise (ch_rise[g])
    );
  end

  // Only channel 2 clocks the noise; the other rise strobes are intentionally dropped.
  assign unused_rise = ^ch_rise[1:0];

  assign shift_due = (noise_r.rate == 2'd3) ? ch_rise[2]
                                            : (tick && (ncnt == noise_last(noise_r.rate)));

  // Noise divider and LFSR; a write to the noise register reseeds and beats any pending shift.
  always_ff @(posedge CLK) begin
    if (RST || noise_wr) begin
      lfsr <= LFSR_SEED;
      ncnt <= '0;
    end else begin
      if (tick && (noise_r.rate != 2'd3)) begin
        ncnt <= (ncnt == noise_last(noise_r.rate)) ? '0 : ncnt + NCNT_W'(1);
      end
      if (shift_due) begin
        lfsr <= lfsr_next(lfsr, noise_r.white);
      end
    end
  end

  assign vol0   = vol_r[0];
  assign vol1   = vol_r[1];
  assign vol2   = vol_r[2];
  assign vol3   = vol_r[3];
  assign ch0out = ch_out[0];
  assign ch1out = ch_out[1];
  assign ch2out = ch_out[2];
  assign ch3out = lfsr[0];

endmodule

// File: tb/tb_ti_psg_gen.sv
// tb/tb_ti_psg_gen.sv - self-checking bench for ti_psg_gen
module tb_ti_psg_gen;

  localparam int CLK_DIV = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic ch0out, ch1out, ch2out, ch3out;
  logic [19:0] dut_pack;

  ti_psg_gen_if bus ();

  ti_psg_gen #(.CLK_DIV(CLK_DIV)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .wr     (bus),
    .vol0   (vol0),
    .vol1   (vol1),
    .vol2   (vol2),
    .vol3   (vol3),
    .ch0out (ch0out),
    .ch1out (ch1out),
    .ch2out (ch2out),
    .ch3out (ch3out)
  );

  always #5 CLK = ~CLK;

  assign dut_pack = {vol0, vol1, vol2, vol3, ch0out, ch1out, ch2out, ch3out};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model: event-scheduled, tick-indexed ----------------
  int m_edge, m_tick, m_nt, m_lfsr, m_lch, m_rate;
  bit m_lvol, m_white;
  int m_vol [4];
  int m_tone [3];
  int m_next [3];
  bit m_sq [3];

  function automatic int lfsr_step(input int l, input bit white);
    int fb;
    fb = white ? ((l ^ (l >> 1)) & 1) : (l & 1);
    return (l >> 1) | (fb << 14);
  endfunction

  always @(posedge CLK) begin
    bit rise2;
    logic [7:0] d;
    if (RST) begin
      m_edge = 0; m_tick = 0; m_nt = 0; m_lfsr = 'h4000;
      m_lch = 0; m_lvol = 0; m_white = 0; m_rate = 0;
      for (int i = 0; i < 4; i++) m_vol[i] = 15;
      for (int i = 0; i < 3; i++) begin m_tone[i] = 0; m_next[i] = 1; m_sq[i] = 0; end
    end else begin
      m_edge++;
      rise2 = 0;
      if (m_edge % CLK_DIV == 0) begin
        m_tick++;
        for (int c = 0; c < 3; c++) begin
          if (m_tick >= m_next[c]) begin
            if (c == 2 && !m_sq[2] && m_tone[2] > 1) rise2 = 1;
            m_sq[c]   = !m_sq[c];
            m_next[c] = m_tick + ((m_tone[c] > 1) ? m_tone[c] : 1);
          end
        end
        if (m_rate != 3) begin
          m_nt++;
          if (m_nt % (32 << m_rate) == 0) m_lfsr = lfsr_step(m_lfsr, m_white);
        end
      end
      if (m_rate == 3 && rise2) m_lfsr = lfsr_step(m_lfsr, m_white);
      if (bus.wr_en) begin
        d = bus.wr_data;
        if (d[7]) begin m_lch = int'(d[6:5]); m_lvol = d[4]; end
        if (m_lvol) m_vol[m_lch] = int'(d[3:0]);
        else if (m_lch == 3) begin
          m_white = d[2]; m_rate = int'(d[1:0]); m_lfsr = 'h4000; m_nt = 0;
        end else if (d[7]) m_tone[m_lch] = (m_tone[m_lch] & 'h3F0) | int'(d[3:0]);
        else m_tone[m_lch] = int'(d[5:0]) * 16 + (m_tone[m_lch] & 'hF);
      end
    end
  end

  function automatic logic [19:0] model_pack();
    logic [19:0] p;
    p[19:16] = 4'(m_vol[0]);
    p[15:12] = 4'(m_vol[1]);
    p[11:8]  = 4'(m_vol[2]);
    p[7:4]   = 4'(m_vol[3]);
    p[3] = (m_tone[0] <= 1) ? 1'b1 : m_sq[0];
    p[2] = (m_tone[1] <= 1) ? 1'b1 : m_sq[1];
    p[1] = (m_tone[2] <= 1) ? 1'b1 : m_sq[2];
    p[0] = m_lfsr[0];
    return p;
  endfunction

  always @(negedge CLK) begin
    if (chk_en && (cyc % 8 == 0)) check("model", int'(dut_pack), int'(model_pack()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [7:0] b);
    @(negedge CLK);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge CLK);
    bus.wr_en   = 1'b0;
  endtask

  function automatic logic chan(input int idx);
    case (idx)
      0: return ch0out;
      1: return ch1out;
      2: return ch2out;
      default: return ch3out;
    endcase
  endfunction

  task automatic wait_change(input int idx, input int bound, output int stamp);
    logic v0;
    int n;
    v0 = chan(idx);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (chan(idx) == v0 && n < bound);
    stamp = cyc;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] vols;
  } vec_t;

  vec_t vt [8];

  initial begin
    int t0, t1, t2, t3, t4, w;

    vt[0] = '{8'h90, 16'h0FFF};
    vt[1] = '{8'hDA, 16'h0FAF};
    vt[2] = '{8'h9F, 16'hFFAF};
    vt[3] = '{8'h03, 16'h3FAF};
    vt[4] = '{8'hBC, 16'h3CAF};
    vt[5] = '{8'h07, 16'h37AF};
    vt[6] = '{8'hFF, 16'h37AF};
    vt[7] = '{8'h02, 16'h37A2};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;

    // reset state and hold with no writes
    check("reset_state", int'(dut_pack), 20'hFFFFE);
    repeat (40) @(negedge CLK);
    check("reset_hold", int'(dut_pack), 20'hFFFFE);

    // volume table
    for (int i = 0; i < 8; i++) begin
      wr(vt[i].data);
      check($sformatf("vol_vec%0d", i), int'({vol0, vol1, vol2, vol3}), int'(vt[i].vols));
    end

    // tone 0 = 254, then data 0x00 -> tone 0x00E
    wr(8'h8E);
    wr(8'h0F);
    wait_change(0, 5000, t0);
    wait_change(0, 5000, t0);
    wait_change(0, 5000, t0);
    wait_change(0, 5000, t1);
    check("tone0_half", t1 - t0, 4064);
    wr(8'h00);
    wait_change(0, 5000, t2);
    check("tone0_current_half", t2 - t1, 4064);
    wait_change(0, 5000, t3);
    check("tone0_new_half_a", t3 - t2, 224);
    wait_change(0, 5000, t4);
    check("tone0_new_half_b", t4 - t3, 224);

    // white noise, rate 0
    wr(8'hE4);
    w = cyc;
    check("white_seed_out", int'(ch3out), 0);
    wait_change(3, 8000, t1);
    check_range("white_first_rise", t1 - w, 7153, 7168);
    check("white_level_after_14", int'(ch3out), 1);
    wait_change(3, 2000, t2);
    check("white_pulse_width", t2 - t1, 512);

    // periodic noise, rate 0
    wr(8'hE0);
    w = cyc;
    wait_change(3, 8000, t1);
    check_range("periodic_first_rise", t1 - w, 7153, 7168);
    wait_change(3, 2000, t2);
    check("periodic_pulse_width", t2 - t1, 512);
    wait_change(3, 8000, t3);
    check("periodic_period", t3 - t1, 7680);

    // periodic noise clocked by tone 2 = 10
    wr(8'hCA);
    wr(8'h00);
    wr(8'hE3);
    wait_change(3, 6000, t1);
    wait_change(3, 1000, t2);
    check("rate3_pulse_width", t2 - t1, 320);
    wait_change(3, 6000, t3);
    check("rate3_period", t3 - t1, 4800);

    // reset mid-run with the latch on ch2 volume, wr_en ignored during reset
    wr(8'hD3);
    check("vol2_before_reset", int'(vol2), 3);
    repeat (200) @(negedge CLK);
    RST = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h9A;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bus.wr_en = 1'b0;
    check("midrun_reset_state", int'(dut_pack), 20'hFFFFE);
    wr(8'h05);
    check("after_reset_vols", int'({vol0, vol1, vol2, vol3}), 16'hFFFF);
    wait_change(0, 2000, t0);
    wait_change(0, 2000, t0);
    wait_change(0, 2000, t1);
    check("after_reset_tone0_half", t1 - t0, 1280);

    // random command stream against the model
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(4, 40)) @(negedge CLK);
      if (i == 250) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
      wr(8'($urandom));
    end
    repeat (64) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
